status_flag_unit: RTL and testbench

Producer side of the condition-check path: computes N, Z, C, V for the instruction in the EXE stage, holds them in the architectural status register, and returns the current flags to the ID stage, where they are checked against the 4-bit condition field. Also raises a hazard when a conditional instruction in ID would read flags that an S-setting instruction in EXE has not yet committed. Sits between the EXE-stage ALU operand muxes and the ID-stage condition logic.

---
 rtl/status_flag_unit_pkg.sv | 20 ++
 rtl/status_flag_unit_if.sv | 31 +++
 rtl/status_flag_unit_flag_gen.sv | 76 +++++++
 rtl/status_flag_unit.sv | 50 +++++
 tb/tb_status_flag_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/status_flag_unit_pkg.sv
// Shared constants for the status flag path: ALU command codes and flag bit positions
// within the {N, Z, C, V} status word.
package status_flag_unit_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/status_flag_unit_if.sv
// EXE/ID-side signal bundle of the status flag unit; master drives the EXE instruction
// and ID request, slave (the flag unit) returns result, status and hazard.
interface status_flag_unit_if #(
    parameter int DATA_W = 32
);
    logic              ex_valid;
    logic              ex_s;
    logic [3:0]        ex_cmd;
    logic [DATA_W-1:0] ex_op_a;
    logic [DATA_W-1:0] ex_op_b;
    logic              ex_shift_carry;
    logic              flush;
    logic              freeze;
    logic              id_cond_used;
    logic [3:0]        status;
    logic              status_hazard;
    logic [DATA_W-1:0] ex_result;

    modport master (
        output ex_valid, ex_s, ex_cmd, ex_op_a, ex_op_b, ex_shift_carry,
        output flush, freeze, id_cond_used,
        input  status, status_hazard, ex_result
    );

    modport slave (
        input  ex_valid, ex_s, ex_cmd, ex_op_a, ex_op_b, ex_shift_carry,
        input  flush, freeze, id_cond_used,
        output status, status_hazard, ex_result
    );

endinterface

// File: rtl/status_flag_unit_flag_gen.sv
// Combinational ALU-equivalent result and next {N, Z, C, V} for the EXE instruction.
module flag_gen
    import status_flag_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              shift_carry,
    input  logic              cin,
    input  logic              v_old,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        next_flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic            c;
    logic            v;
    logic            arith_add;
    logic            arith_sub;

    always_comb begin
        sum       = '0;
        result    = b;
        c         = shift_carry;
        v         = v_old;
        arith_add = 1'b0;
        arith_sub = 1'b0;
        case (cmd)
            CMD_MOV: result = b;
            CMD_MVN: result = ~b;
            CMD_ADD: begin
                sum       = {1'b0, a} + {1'b0, b};
                arith_add = 1'b1;
            end
            CMD_ADC: begin
                sum       = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
                arith_add = 1'b1;
            end
            // Subtraction as a + ~b + carry so C reads as "no borrow"
            CMD_SUB: begin
                sum       = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                arith_sub = 1'b1;
            end
            CMD_SBC: begin
                sum       = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, cin};
                arith_sub = 1'b1;
            end
            CMD_AND: result = a & b;
            CMD_ORR: result = a | b;
            CMD_EOR: result = a ^ b;
            default: result = b;
        endcase

        if (arith_add || arith_sub) begin
            result = sum[DATA_W-1:0];
            c      = sum[DATA_W];
        end
        if (arith_add) begin
            v = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
        end
        if (arith_sub) begin
            v = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
        end

        next_flags         = '0;
        next_flags[FLAG_N] = result[MSB];
        next_flags[FLAG_Z] = (result == '0);
        next_flags[FLAG_C] = c;
        next_flags[FLAG_V] = v;
    end

endmodule

// File: rtl/status_flag_unit.sv
// Status register, optional same-cycle bypass and ID flag hazard around flag_gen.
// Build option: define STATUS_BYPASS_EN to forward fresh flags to ID instead of stalling.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    status_flag_unit_if.slave   bus
);

    logic [3:0]        sreg;
    logic [3:0]        next_flags;
    logic [DATA_W-1:0] result;
    logic              upd;

    assign upd = bus.ex_valid & bus.ex_s & ~bus.flush & ~bus.freeze;

    // Carry-in always comes from the committed register, never from the bypass
    flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
        .cmd         (bus.ex_cmd),
        .a           (bus.ex_op_a),
        .b           (bus.ex_op_b),
        .shift_carry (bus.ex_shift_carry),
        .cin         (sreg[FLAG_C]),
        .v_old       (sreg[FLAG_V]),
        .result      (result),
        .next_flags  (next_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= 4'b0000;
        end else if (upd) begin
            sreg <= next_flags;
        end
    end

    assign bus.ex_result = result;

`ifdef STATUS_BYPASS_EN
    assign bus.status        = upd ? next_flags : sreg;
    assign bus.status_hazard = 1'b0;
`else
    assign bus.status        = sreg;
    assign bus.status_hazard = bus.id_cond_used & bus.ex_valid & bus.ex_s & ~bus.flush;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed and randomized bench for status_flag_unit against an arithmetic reference model.
module tb_status_flag_unit;

    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    status_flag_unit_if #(.DATA_W(DATA_W)) bus ();

    status_flag_unit #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [3:0]  sreg_m;
    logic        t_rst, t_valid, t_s, t_sc, t_flush, t_freeze, t_idc;
    logic [3:0]  t_cmd;
    logic [31:0] t_a, t_b;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned/signed integer arithmetic on 64-bit values; returns {result, N, Z, C, V}
    function automatic logic [35:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                            input logic [31:0] b, input logic sc,
                                            input logic cin, input logic vold);
        longint ua, ub, sa, sb, u, s, borrow;
        logic [31:0] r;
        logic c, v, arith;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = $signed(a);
        sb = $signed(b);
        c = sc;
        v = vold;
        arith = 1'b1;
        u = 0;
        s = 0;
        case (cmd)
            4'd2: begin u = ua + ub; s = sa + sb; c = (u >= 64'sd4294967296); end
            4'd3: begin u = ua + ub + cin; s = sa + sb + cin; c = (u >= 64'sd4294967296); end
            4'd4: begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
            4'd5: begin
                borrow = cin ? 0 : 1;
                u = ua - ub - borrow;
                s = sa - sb - borrow;
                c = (ua >= ub + borrow);
            end
            default: arith = 1'b0;
        endcase
        if (arith) begin
            r = u[31:0];
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            case (cmd)
                4'd9:    r = ~b;
                4'd6:    r = a & b;
                4'd7:    r = a | b;
                4'd8:    r = a ^ b;
                default: r = b;
            endcase
        end
        return {r, r[31], (r == 32'd0), c, v};
    endfunction

    task automatic set_op(input logic valid, input logic s, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b, input logic sc,
                          input logic fl, input logic fr, input logic idc);
        t_valid = valid; t_s = s; t_cmd = cmd; t_a = a; t_b = b;
        t_sc = sc; t_flush = fl; t_freeze = fr; t_idc = idc;
        rst                = t_rst;
        bus.ex_valid       = valid;
        bus.ex_s           = s;
        bus.ex_cmd         = cmd;
        bus.ex_op_a        = a;
        bus.ex_op_b        = b;
        bus.ex_shift_carry = sc;
        bus.flush          = fl;
        bus.freeze         = fr;
        bus.id_cond_used   = idc;
    endtask

    task automatic set_idle();
        set_op(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One stage cycle: check outputs mid-cycle against the model, then commit the model
    task automatic run_cycle();
        logic [35:0] m;
        logic        upd;
        logic [3:0]  exp_status;
        logic        exp_haz;
        @(negedge clk);
        m   = ref_alu(t_cmd, t_a, t_b, t_sc, sreg_m[1], sreg_m[0]);
        upd = t_valid & t_s & ~t_flush & ~t_freeze;
`ifdef STATUS_BYPASS_EN
        exp_status = upd ? m[3:0] : sreg_m;
        exp_haz    = 1'b0;
`else
        exp_status = sreg_m;
        exp_haz    = t_idc & t_valid & t_s & ~t_flush;
`endif
        check_eq("ex_result", bus.ex_result, m[35:4]);
        check_eq("status", bus.status, exp_status);
        check_eq("status_hazard", bus.status_hazard, exp_haz);
        @(posedge clk);
        if (t_rst) sreg_m = 4'b0000;
        else if (upd) sreg_m = m[3:0];
        #1;
    endtask

    // Issue one S op, then an idle cycle, then compare committed flags to a constant
    task automatic op_then_expect(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, input logic sc, input logic [3:0] exp);
        set_op(1'b1, 1'b1, cmd, a, b, sc, 1'b0, 1'b0, 1'b0);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq(tag, bus.status, exp);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        sreg_m = 4'b0000;
        t_rst  = 1'b1;
        set_idle();
        @(posedge clk); #1;
        run_cycle();
        run_cycle();
        check_eq("reset_status", bus.status, 4'b0000);
        check_eq("reset_hazard", bus.status_hazard, 1'b0);
        t_rst = 1'b0;
        set_idle();

        set_op(1'b1, 1'b0, 4'b0010, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("add_nos", bus.status, 4'b0000);

        op_then_expect("subs_eq", 4'b0100, 32'd5, 32'd5, 1'b0, 4'b0110);
        op_then_expect("subs_lt", 4'b0100, 32'd3, 32'd5, 1'b0, 4'b1000);
        op_then_expect("adds_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'b1001);
        op_then_expect("adds_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'b0110);

        set_op(1'b1, 1'b1, 4'b0011, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_eq("adc_result", bus.ex_result, 32'd1);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("adcs_flags", bus.status, 4'b0000);

        set_op(1'b1, 1'b1, 4'b0101, 32'd5, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 check_eq("sbc_result", bus.ex_result, 32'd1);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("sbcs_flags", bus.status, 4'b0010);

        op_then_expect("adds_setv", 4'b0010, 32'h7FFF_FFFF, 32'd1, 1'b0, 4'b1001);

        set_op(1'b1, 1'b1, 4'b0110, 32'hF0, 32'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 check_eq("flush_hazard", bus.status_hazard, 1'b0);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("flush_hold", bus.status, 4'b1001);

        op_then_expect("ands_zero", 4'b0110, 32'hF0, 32'h0F, 1'b1, 4'b0111);

        set_op(1'b1, 1'b1, 4'b0100, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
`ifdef STATUS_BYPASS_EN
        check_eq("byp_status", bus.status, 4'b1000);
        check_eq("byp_hazard", bus.status_hazard, 1'b0);
`else
        check_eq("haz_status", bus.status, 4'b0111);
        check_eq("haz_hazard", bus.status_hazard, 1'b1);
`endif
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("haz_commit", bus.status, 4'b1000);
        check_eq("haz_clear", bus.status_hazard, 1'b0);

        set_op(1'b1, 1'b1, 4'b0010, 32'd1, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        run_cycle();
        set_idle();
        run_cycle();
        check_eq("freeze_hold", bus.status, 4'b1000);

        t_rst = 1'b1;
        set_op(1'b1, 1'b1, 4'b0100, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle();
        t_rst = 1'b0;
        set_idle();
        run_cycle();
        check_eq("midrst_clear", bus.status, 4'b0000);

        for (int i = 0; i < 500; i++) begin
            t_rst = ($urandom_range(0, 63) == 0);
            set_op($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                   4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
            run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
